// File: rtl/mult_div_unit_pkg.sv
// Shared MDU definitions (mdu_defs): opcode encodings, default latencies, op-class helpers.
// Defining MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU opcodes.
package mdu_defs;

  localparam int unsigned MULT_CYCLES_DEF = 32'd5;
  localparam int unsigned DIV_CYCLES_DEF  = 32'd10;

`ifdef MDU_MADD_EN
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;
`else
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;
`endif

  // Ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mul_op(input logic [3:0] op);
    logic res;
    case (op)
      OP_MULT, OP_MULTU: res = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    logic res;
    case (op)
      OP_DIV, OP_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage <-> multiply/divide unit bundle. The pipeline side uses master, the MDU uses slave.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_result;

  modport master (
    output start, mdu_op, rs_data, rt_data,
    input  busy, hi, lo, mdu_result
  );

  modport slave (
    input  start, mdu_op, rs_data, rt_data,
    output busy, hi, lo, mdu_result
  );
endinterface

// File: rtl/mult_div_unit_calc.sv
// mdu_calc: combinational 64-bit {hi,lo} result for a multiply/divide op.
// Divide by zero returns the current {hi,lo}; MDU_MADD_EN adds accumulate forms.
module mdu_calc
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] hl_s;
  logic [63:0] prod_sgn_s;
  logic [63:0] prod_uns_s;
  logic        div_sgn_s;
  logic        div_zero_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] dvd_s;
  logic [31:0] dvs_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  assign hl_s       = {hi, lo};
  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_sgn_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_uns_s = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow.
  assign div_sgn_s  = (op == OP_DIV);
  assign div_zero_s = (b == 32'd0);
  assign a_mag_s    = a[31] ? (32'd0 - a) : a;
  assign b_mag_s    = b[31] ? (32'd0 - b) : b;
  assign dvd_s      = div_sgn_s ? a_mag_s : a;
  assign dvs_s      = div_zero_s ? 32'd1 : (div_sgn_s ? b_mag_s : b);
  assign uq_s       = dvd_s / dvs_s;
  assign ur_s       = dvd_s % dvs_s;
  assign quo_s      = (div_sgn_s && (a[31] ^ b[31])) ? (32'd0 - uq_s) : uq_s;
  assign rem_s      = (div_sgn_s && a[31]) ? (32'd0 - ur_s) : ur_s;

  // Result select by opcode.
  always_comb begin
    result = hl_s;
    case (op)
      OP_MULT:  result = prod_sgn_s;
      OP_MULTU: result = prod_uns_s;
      OP_DIV, OP_DIVU: begin
        if (div_zero_s) begin
          result = hl_s;
        end else begin
          result = {rem_s, quo_s};
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = hl_s + prod_sgn_s;
      OP_MADDU: result = hl_s + prod_uns_s;
      OP_MSUB:  result = hl_s - prod_sgn_s;
      OP_MSUBU: result = hl_s - prod_uns_s;
`endif
      default:  result = hl_s;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning HI/LO, with busy for hazard stalls.
// Optional MDU_MADD_EN enables the multiply-accumulate opcodes (MULT_CYCLES latency).
module mult_div_unit
  import mdu_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave mdu
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [63:0]      pend_r, pend_nx_s;
  logic [31:0]      hi_r, hi_nx_s;
  logic [31:0]      lo_r, lo_nx_s;
  logic [63:0]      calc_s;

  mdu_calc u_calc (
    .op     (mdu.mdu_op),
    .a      (mdu.rs_data),
    .b      (mdu.rt_data),
    .hi     (hi_r),
    .lo     (lo_r),
    .result (calc_s)
  );

  // Next-state: accept ops only when idle; commit pending on the last busy edge.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    pend_nx_s  = pend_r;
    hi_nx_s    = hi_r;
    lo_nx_s    = lo_r;
    case (state_r)
      ST_IDLE: begin
        if (mdu.start) begin
          if (is_mul_op(mdu.mdu_op)) begin
            pend_nx_s  = calc_s;
            cnt_nx_s   = MUL_LAT;
            state_nx_s = ST_RUN;
          end else if (is_div_op(mdu.mdu_op)) begin
            pend_nx_s  = calc_s;
            cnt_nx_s   = DIV_LAT;
            state_nx_s = ST_RUN;
          end else if (mdu.mdu_op == OP_MTHI) begin
            hi_nx_s = mdu.rs_data;
          end else if (mdu.mdu_op == OP_MTLO) begin
            lo_nx_s = mdu.rs_data;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_W'(1)) begin
          hi_nx_s    = pend_r[63:32];
          lo_nx_s    = pend_r[31:0];
          cnt_nx_s   = '0;
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        cnt_nx_s   = '0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      pend_r  <= 64'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      pend_r  <= pend_nx_s;
      hi_r    <= hi_nx_s;
      lo_r    <= lo_nx_s;
    end
  end

  assign mdu.busy       = (state_r == ST_RUN);
  assign mdu.hi         = hi_r;
  assign mdu.lo         = lo_r;
  assign mdu.mdu_result = (mdu.mdu_op == OP_MFHI) ? hi_r : lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed plan cases plus randomized ops against
// an arithmetic reference model; a monitor checks each commit when busy falls.
module tb_mult_div_unit;

  localparam logic [3:0] C_NONE = 4'd0, C_MULT = 4'd1, C_MULTU = 4'd2, C_DIV = 4'd3,
                         C_DIVU = 4'd4, C_MFHI = 4'd5, C_MFLO = 4'd6, C_MTHI = 4'd7,
                         C_MTLO = 4'd8, C_MADD = 4'd9, C_MADDU = 4'd10, C_MSUB = 4'd11,
                         C_MSUBU = 4'd12;

  typedef struct packed {
    logic [63:0] res;
    int          lat;
  } sb_t;

  logic clk;
  logic reset;
  mult_div_unit_if mdu_bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  sb_t         sb_q[$];
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;
  logic [63:0] mdl_pend = 64'd0;
  int          mdl_busy_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_lat(input logic [3:0] op);
    case (op)
      C_MULT, C_MULTU: return 5;
      C_DIV, C_DIVU:   return 10;
`ifdef MDU_MADD_EN
      C_MADD, C_MADDU, C_MSUB, C_MSUBU: return 5;
`endif
      default:         return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      q;
    longint      r;
    logic [63:0] hl = {h, l};
    logic [63:0] pu = {32'd0, a} * {32'd0, b};
    logic [63:0] ps = 64'(sa * sb);
    case (op)
      C_MULT:  return ps;
      C_MULTU: return pu;
      C_DIV: begin
        if (b == 32'd0) return hl;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      C_DIVU: begin
        if (b == 32'd0) return hl;
        return {a % b, a / b};
      end
      C_MADD:  return hl + ps;
      C_MADDU: return hl + pu;
      C_MSUB:  return hl - ps;
      C_MSUBU: return hl - pu;
      default: return hl;
    endcase
  endfunction

  // One cycle: drive, check visible state against the model, cross the edge, update model.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    logic acc;
    int   n;
    mdu_bus.start   = st;
    mdu_bus.mdu_op  = op;
    mdu_bus.rs_data = a;
    mdu_bus.rt_data = b;
    #1;
    check("busy", 64'(mdu_bus.busy), 64'(mdl_busy_left > 0));
    check("hi", 64'(mdu_bus.hi), 64'(mdl_hi));
    check("lo", 64'(mdu_bus.lo), 64'(mdl_lo));
    check("mdu_result", 64'(mdu_bus.mdu_result), 64'((op == C_MFHI) ? mdl_hi : mdl_lo));
    acc = st && (mdl_busy_left == 0);
    @(posedge clk);
    if (mdl_busy_left > 0) begin
      mdl_busy_left--;
      if (mdl_busy_left == 0) {mdl_hi, mdl_lo} = mdl_pend;
    end
    if (acc) begin
      n = ref_lat(op);
      if (n > 0) begin
        mdl_pend      = ref_calc(op, a, b, mdl_hi, mdl_lo);
        mdl_busy_left = n;
        sb_q.push_back('{res: mdl_pend, lat: n});
      end else if (op == C_MTHI) begin
        mdl_hi = a;
      end else if (op == C_MTLO) begin
        mdl_lo = a;
      end
    end
    #1;
    mdu_bus.start = 1'b0;
  endtask

  task automatic drain();
    while (mdl_busy_left > 0) issue(C_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic expect_hl(input string name, input logic [31:0] h, input logic [31:0] l);
    check({name, "_hi"}, 64'(mdu_bus.hi), 64'(h));
    check({name, "_lo"}, 64'(mdu_bus.lo), 64'(l));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 9));
      default: return 32'($urandom());
    endcase
  endfunction

  // Monitor: each busy falling edge is a commit; compare it with the oldest expectation.
  initial begin
    logic mon_prev = 1'b0;
    int   mon_cnt  = 0;
    sb_t  e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_prev = 1'b0;
        mon_cnt  = 0;
      end else begin
        if (mdu_bus.busy) begin
          mon_cnt++;
        end else if (mon_prev) begin
          if (sb_q.size() == 0) begin
            check("commit_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("commit_hi", 64'(mdu_bus.hi), 64'(e.res[63:32]));
            check("commit_lo", 64'(mdu_bus.lo), 64'(e.res[31:0]));
            check("busy_len", 64'(mon_cnt), 64'(e.lat));
          end
          mon_cnt = 0;
        end
        mon_prev = mdu_bus.busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    mdu_bus.start   = 1'b0;
    mdu_bus.mdu_op  = C_NONE;
    mdu_bus.rs_data = 32'd0;
    mdu_bus.rt_data = 32'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    expect_hl("reset", 32'd0, 32'd0);
    check("reset_busy", 64'(mdu_bus.busy), 64'd0);

    issue(C_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
    drain();
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue(C_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    drain();
    expect_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    drain();
    expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(C_DIVU, 32'd7, 32'd0, 1'b1);
    drain();
    expect_hl("divu_by0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(C_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    mdu_bus.mdu_op = C_MFHI;
    #1;
    check("mfhi_after_mthi", 64'(mdu_bus.mdu_result), 64'h1234_5678);
    check("mthi_no_busy", 64'(mdu_bus.busy), 64'd0);

    // Starts during busy cycle 3 must be dropped.
    issue(C_DIV, 32'd100, 32'd7, 1'b1);
    issue(C_NONE, 32'd0, 32'd0, 1'b0);
    issue(C_NONE, 32'd0, 32'd0, 1'b0);
    issue(C_MULT, 32'd9, 32'd9, 1'b1);
    issue(C_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1);
    drain();
    expect_hl("div_ignore", 32'd2, 32'd14);

    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();
    expect_hl("div_ovf", 32'd0, 32'h8000_0000);

    issue(C_MTHI, 32'hA5A5_0001, 32'd0, 1'b1);
    issue(C_MULT, 32'd3, 32'd4, 1'b1);
    issue(C_NONE, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(mdu_bus.busy), 64'd0);
    expect_hl("abort", 32'd0, 32'd0);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    mdl_busy_left = 0;
    sb_q.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) issue(C_NONE, 32'd0, 32'd0, 1'b0);
    expect_hl("post_abort", 32'd0, 32'd0);

`ifdef MDU_MADD_EN
    issue(C_MTHI, 32'd0, 32'd0, 1'b1);
    issue(C_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1);
    issue(C_MADDU, 32'd1, 32'd1, 1'b1);
    drain();
    expect_hl("maddu", 32'd1, 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), 1'b1);
      repeat ($urandom_range(0, 4)) issue(4'($urandom_range(0, 15)), pick(), pick(), 1'b0);
    end
    drain();
    issue(C_NONE, 32'd0, 32'd0, 1'b0);
    issue(C_NONE, 32'd0, 32'd0, 1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential multiply/divide unit for the pipelined CPU's E stage. It accepts MULT/MULTU/DIV/DIVU plus HI/LO moves and models fixed multi-cycle latency with a `busy` flag, which the hazard unit uses to stall. It owns the HI/LO registers. It drives the MDU-result source of the GRF write-data selection as the MFHI/MFLO read value, which is pipelined to W.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (and MADD family).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low; clears all state.
- `start`  in  1  — qualifies `mdu_op` for one cycle (E-stage instruction valid and not stalled).
- `mdu_op`  in  4  — operation code; encodings live in the shared package.
- `rs_data`  in  32  — operand A (dividend / multiplicand / MT source).
- `rt_data`  in  32  — operand B (divisor / multiplier).
- `busy`  out  1  — a multi-cycle operation is in flight.
- `hi`  out  32  — HI register.
- `lo`  out  32  — LO register.
- `mdu_result`  out  32  — `hi` when `mdu_op`==MFHI, else `lo` (combinational).

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, counter=0, pending result=0. Asynchronous assert. Aborts any in-flight operation, with no HI/LO commit.
- States: IDLE (counter==0, busy=0) and RUN (counter>0, busy=1).
- IDLE, `start` with MULT/MULTU/DIV/DIVU:
  - Operands are captured.
  - The 64-bit result is computed and stored in a pending {hi,lo} register.
  - counter is loaded with the latency; go to RUN.
- RUN: counter decrements each edge. On the edge where counter==1, pending is written to `hi`/`lo`, busy drops, and the block returns to IDLE.
- MULT: signed 32×32→64; `hi`=[63:32], `lo`=[31:0]. MULTU: unsigned.
- DIV: `lo`=signed quotient truncated toward zero; `hi`=remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - DIVU is the unsigned form.
- Divide by zero: full latency still elapses, and `hi`/`lo` are left unchanged at commit.
- MTHI/MTLO with `start` in IDLE: `hi` or `lo` is set to `rs_data` at that edge, with no busy.
- MFHI/MFLO/NONE: no state change. `mdu_result` reads the current registers.
- `start` while `busy`=1: ignored entirely, including MT ops. The hazard unit guarantees stall. The bench checks that HI/LO and the counter are unaffected.
- Unknown `mdu_op` codes behave as NONE.

## Timing
- `start` on edge T makes `busy` high from T+1 through T+N inclusive, where N = MULT_CYCLES or DIV_CYCLES.
- New HI/LO values are visible after edge T+N, and `busy` is 0 from T+N+1.
- A back-to-back `start` on the first idle cycle is accepted.
- MT write: new value visible the cycle after the edge.
- `mdu_result` has zero latency from `mdu_op`/`hi`/`lo`.
- The hazard unit stalls D when D holds an MDU instruction and (`busy` or `start`).

## Configuration
- `MDU_MADD_EN` defined:
  - Adds MADD, MADDU, MSUB, MSUBU opcodes.
  - Pending = {hi,lo} ± product, with the product signed or unsigned per op.
  - {hi,lo} is sampled at the start edge, and wraps modulo 2^64.
  - Latency is MULT_CYCLES.
- `MDU_MADD_EN` undefined: these codes are absent and decode as NONE.

## Structure
- Shared package/header `mdu_defs` holds:
  - `mdu_op` encodings: NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
  - Default latency constants.
- The same header is used by the control decoder and the hazard unit.
- One sub-module: `mdu_calc`, a combinational 64-bit result generator from op/operands/current HI-LO, including the divide-by-zero hold.
- The top level holds the counter, pending register, and HI/LO.

## Test plan
- MULT, rs=0xFFFFFFFF, rt=2 → `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV, rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → hi/lo unchanged, busy still 10 cycles.
- MTHI 0x12345678, then MFHI next cycle → `mdu_result`=0x12345678, no busy.
- DIV started, then on busy cycle 3 drive `start` with MULT and MTLO → both ignored; only the DIV result commits at T+10.
- Assert `reset` low mid-MULT (busy cycle 2) → immediately busy=0, hi=lo=0; no commit after release.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, then MADDU rs=1, rt=1 → hi=1, lo=0 after 5 cycles.
